// File: rtl/huff_decoder.sv
// huff_decoder: receive-side Huffman decoder for the 3-symbol encoder.
// Loads a 3-entry codebook as character/code word pairs over io_in[8:0].
// It then decodes a serial MSB-first bitstream into 5-bit symbols.
// Optional build macro: HUFF_DEC_CHECK_EN enables tag and mask checking
// during the load phase, with an error pulse for each rejected word.
//
// Handshake: there is no backpressure. io_in[9] (word_strobe) and
// io_in[10] (bit_valid) each qualify one transfer on every rising edge
// where they are high. io_out[5] (sym_valid) and io_out[6] (error) are
// single-cycle pulses that the consumer must sample every cycle.
module huff_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  localparam logic [1:0] S_LOAD_CHAR = 2'd0;
  localparam logic [1:0] S_LOAD_CODE = 2'd1;
  localparam logic [1:0] S_DECODE    = 2'd2;

  // Code length implied by a mask; a non-contiguous mask behaves as an empty entry.
  function automatic logic [1:0] mask_len(input logic [2:0] m);
    case (m)
      3'b001:  mask_len = 2'd1;
      3'b011:  mask_len = 2'd2;
      3'b111:  mask_len = 2'd3;
      default: mask_len = 2'd0;
    endcase
  endfunction

  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [4:0] r_sym  [0:2];
  logic [2:0] r_mask [0:2];
  logic [2:0] r_val  [0:2];
  logic [2:0] r_acc;
  logic [1:0] r_len;
  logic [2:0] r_count;
  logic [4:0] r_symbol;
  logic       r_sym_valid;
  logic       r_error;
  logic       r_table_ready;

  logic [8:0] w_word;
  logic       w_strobe;
  logic       w_bit_valid;
  logic       w_bit;
  logic [2:0] w_acc_next;
  logic [1:0] w_len_next;
  logic       w_hit;
  logic [4:0] w_hit_sym;
  logic       w_char_ok;
  logic       w_code_ok;
  logic       w_mask_bad;
  logic [2:0] w_unused;

  assign w_word      = io_in[8:0];
  assign w_strobe    = io_in[9];
  assign w_bit_valid = io_in[10];
  assign w_bit       = io_in[11];

  // The encoder's done flag and the tag bits are not needed when tags go unchecked.
  assign w_unused = {io_in[8], io_in[7:6]};

`ifdef HUFF_DEC_CHECK_EN
  assign w_char_ok  = (w_word[7:5] == 3'b011);
  assign w_code_ok  = (w_word[7:6] == 2'b00);
  assign w_mask_bad = (mask_len(w_word[5:3]) == 2'd0) && (w_word[5:3] != 3'b000);
`else
  assign w_char_ok  = 1'b1;
  assign w_code_ok  = 1'b1;
  assign w_mask_bad = 1'b0;
`endif

  // The accumulator and length the current bit would produce; r_len never exceeds 2.
  assign w_acc_next = {r_acc[1:0], w_bit};
  assign w_len_next = r_len + 2'd1;

  // Table search: walk from the top so the lowest matching index is left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_sym = 5'd0;
    for (int i = 2; i >= 0; i--) begin
      if ((mask_len(r_mask[i]) == w_len_next) &&
          (((w_acc_next ^ r_val[i]) & r_mask[i]) == 3'b000)) begin
        w_hit     = 1'b1;
        w_hit_sym = r_sym[i];
      end
    end
  end

  // Load FSM, decode datapath and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_LOAD_CHAR;
      r_idx         <= 2'd0;
      r_acc         <= 3'd0;
      r_len         <= 2'd0;
      r_count       <= 3'd0;
      r_symbol      <= 5'd0;
      r_sym_valid   <= 1'b0;
      r_error       <= 1'b0;
      r_table_ready <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_sym[i]  <= 5'd0;
        r_mask[i] <= 3'd0;
        r_val[i]  <= 3'd0;
      end
    end else begin
      r_sym_valid <= 1'b0;
      r_error     <= 1'b0;
      case (r_state)
        S_LOAD_CHAR: begin
          if (w_strobe) begin
            if (w_char_ok) begin
              r_sym[r_idx] <= w_word[4:0];
              r_state      <= S_LOAD_CODE;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_LOAD_CODE: begin
          if (w_strobe) begin
            if (w_code_ok) begin
              r_mask[r_idx] <= w_word[5:3];
              r_val[r_idx]  <= w_word[2:0];
              r_error       <= w_mask_bad;
              if (r_idx == 2'd2) begin
                r_idx         <= 2'd0;
                r_state       <= S_DECODE;
                r_table_ready <= 1'b1;
              end else begin
                r_idx   <= r_idx + 2'd1;
                r_state <= S_LOAD_CHAR;
              end
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (w_bit_valid) begin
            if (w_hit) begin
              r_symbol    <= w_hit_sym;
              r_sym_valid <= 1'b1;
              r_count     <= r_count + 3'd1;
              r_acc       <= 3'd0;
              r_len       <= 2'd0;
            end else if (w_len_next == 2'd3) begin
              r_error <= 1'b1;
              r_acc   <= 3'd0;
              r_len   <= 2'd0;
            end else begin
              r_acc <= w_acc_next;
              r_len <= w_len_next;
            end
          end
        end
        default: begin
          r_state <= S_LOAD_CHAR;
        end
      endcase
    end
  end

  assign io_out = {1'b0, r_count, r_table_ready, r_error, r_sym_valid, r_symbol};

endmodule
